// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: demand-actuated 4-approach phase scheduler with round-robin vehicle service,
// pedestrian all-red WALK and emergency preemption.
module traffic_phase_scheduler #(
  parameter int unsigned GREEN_MIN = 4,
  parameter int unsigned GREEN_MAX = 10,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned ALL_RED_T = 1,
  parameter int unsigned WALK_T    = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] car_req,
  input  logic       ped_req,
  input  logic       emerg_valid,
  input  logic [1:0] emerg_dir,
  output logic [1:0] light_n,
  output logic [1:0] light_e,
  output logic [1:0] light_s,
  output logic [1:0] light_w,
  output logic       ped_walk,
  output logic [1:0] phase_dir,
  output logic [3:0] pending,
  output logic       emerg_active
);
  typedef enum logic [2:0] {IDLE, GREEN, YELLOW, ALL_RED, WALK} state_t;
  localparam logic [7:0] GMIN_C = 8'(GREEN_MIN - 1);
  localparam logic [7:0] GMAX_C = 8'(GREEN_MAX - 1);
  localparam logic [7:0] Y_C    = 8'(YELLOW_T - 1);
  localparam logic [7:0] AR_C   = 8'(ALL_RED_T - 1);
  localparam logic [7:0] W_C    = 8'(WALK_T - 1);
  state_t     state_q, state_d, arb_state;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] dir_q, dir_d, rr_dir, arb_dir;
  logic [3:0] pend_q, pend_d, demand, cur_oh, new_oh, g_oh, y_oh;
  logic       ped_q, ped_d, emerg_q, emerg_d, ped_set, other, enter_green, enter_walk;
  assign demand = pend_q | car_req;
  assign cur_oh = 4'b0001 << dir_q;
  assign new_oh = 4'b0001 << dir_d;
  assign other  = |(demand & ~cur_oh) | ped_q;
  // Round-robin: nearest requesting approach after the most recent green, wrapping.
  always_comb begin
    rr_dir = dir_q;
    for (int k = 4; k >= 1; k--)
      if (demand[2'(dir_q + 2'(k))]) rr_dir = 2'(dir_q + 2'(k));
  end
  assign arb_state = emerg_valid ? GREEN : (ped_q | ped_req) ? WALK : |demand ? GREEN : IDLE;
  assign arb_dir   = emerg_valid ? emerg_dir : rr_dir;
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    emerg_d = emerg_q;
    ped_set = 1'b0;
    case (state_q)
      IDLE, ALL_RED: begin
        if (state_q == IDLE || cnt_q >= AR_C) begin
          state_d = arb_state;
          dir_d   = arb_state == GREEN ? arb_dir : dir_q;
          emerg_d = emerg_valid;
        end
      end
      GREEN: begin
        if (emerg_valid) begin
          state_d = emerg_dir != dir_q ? YELLOW : GREEN;
          emerg_d = emerg_dir == dir_q;
        end else begin
          emerg_d = 1'b0;
          if (other && cnt_q >= GMIN_C && (!car_req[dir_q] || cnt_q >= GMAX_C)) state_d = YELLOW;
        end
      end
      YELLOW: if (cnt_q >= Y_C) state_d = ALL_RED;
      WALK: begin
        ped_set = emerg_valid;
        if (emerg_valid || cnt_q >= W_C) state_d = ALL_RED;
      end
      default: state_d = ALL_RED;
    endcase
  end
  assign enter_green = state_d == GREEN && state_q != GREEN;
  assign enter_walk  = state_d == WALK && state_q != WALK;
  // The approach being served does not re-latch its own request while green.
  assign pend_d = (pend_q | (car_req & ~(state_q == GREEN ? cur_oh : 4'b0000))) & ~(enter_green ? new_oh : 4'b0000);
  assign ped_d  = ((ped_q | ped_req) & ~enter_walk) | ped_set;
  assign cnt_d  = state_d != state_q ? 8'd0 : cnt_q + {7'd0, ~&cnt_q};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ALL_RED;
      cnt_q   <= '0;
      dir_q   <= 2'd3;
      pend_q  <= '0;
      ped_q   <= 1'b0;
      emerg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      ped_q   <= ped_d;
      emerg_q <= emerg_d;
    end
  end
  assign g_oh         = state_q == GREEN ? cur_oh : 4'b0000;
  assign y_oh         = state_q == YELLOW ? cur_oh : 4'b0000;
  assign light_n      = {g_oh[0], y_oh[0]};
  assign light_e      = {g_oh[1], y_oh[1]};
  assign light_s      = {g_oh[2], y_oh[2]};
  assign light_w      = {g_oh[3], y_oh[3]};
  assign ped_walk     = state_q == WALK;
  assign phase_dir    = dir_q;
  assign pending      = pend_q;
  assign emerg_active = emerg_q;
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler: randomized scoreboard bench against a phase-level reference model.
module tb_traffic_phase_scheduler;
  localparam int GMIN = 4, GMAX = 10, YT = 2, ART = 1, WT = 6;
  localparam int P_IDLE = 0, P_GREEN = 1, P_YELLOW = 2, P_ALLRED = 3, P_WALK = 4;
  typedef struct packed {
    logic [1:0] n, e, s, w;
    logic       walk;
    logic [1:0] dir;
    logic [3:0] pend;
    logic       em;
  } obs_t;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] car_req;
  logic       ped_req, emerg_valid;
  logic [1:0] emerg_dir;
  logic [1:0] light_n, light_e, light_s, light_w, phase_dir;
  logic       ped_walk, emerg_active;
  logic [3:0] pending;
  obs_t       sb[$];
  int         n_tests = 0, n_fail = 0, cycle = 0;
  int         ph, age, dir;
  logic [3:0] mp;
  logic       mped, mem;

  traffic_phase_scheduler #(.GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_T(YT), .ALL_RED_T(ART), .WALK_T(WT)) dut (
    .clk(clk), .reset(reset), .car_req(car_req), .ped_req(ped_req), .emerg_valid(emerg_valid),
    .emerg_dir(emerg_dir), .light_n(light_n), .light_e(light_e), .light_s(light_s), .light_w(light_w),
    .ped_walk(ped_walk), .phase_dir(phase_dir), .pending(pending), .emerg_active(emerg_active)
  );

  initial forever #5 clk = ~clk;

  task automatic model_reset();
    ph = P_ALLRED; age = 0; dir = 3; mp = '0; mped = 1'b0; mem = 1'b0;
  endtask

  // One clock of the intersection, described in terms of phases and elapsed cycles.
  task automatic model_step(input logic [3:0] car, input logic ped, input logic ev, input logic [1:0] ed);
    logic [3:0] dem;
    int nph, ndir, a_ph, a_dir;
    logic nem, ped_again, rivals;
    dem = mp | car;
    nph = ph; ndir = dir; nem = mem; ped_again = 1'b0; a_dir = dir;
    if (ev) begin a_ph = P_GREEN; a_dir = int'(ed); end
    else if (mped || ped) a_ph = P_WALK;
    else if (dem != 0) begin
      a_ph = P_GREEN;
      for (int k = 4; k >= 1; k--) if (dem[(dir + k) % 4]) a_dir = (dir + k) % 4;
    end else a_ph = P_IDLE;
    rivals = mped;
    for (int i = 0; i < 4; i++) if (i != dir && dem[i]) rivals = 1'b1;
    if (ph == P_IDLE || (ph == P_ALLRED && age + 1 >= ART)) begin
      nph = a_ph;
      if (a_ph == P_GREEN) ndir = a_dir;
      nem = ev;
    end else if (ph == P_GREEN) begin
      if (ev) begin
        nem = (int'(ed) == dir);
        if (int'(ed) != dir) nph = P_YELLOW;
      end else begin
        nem = 1'b0;
        if (rivals && age + 1 >= GMIN && (!car[dir] || age + 1 >= GMAX)) nph = P_YELLOW;
      end
    end else if (ph == P_YELLOW) begin
      if (age + 1 >= YT) nph = P_ALLRED;
    end else if (ph == P_WALK) begin
      if (ev) begin nph = P_ALLRED; ped_again = 1'b1; end
      else if (age + 1 >= WT) nph = P_ALLRED;
    end
    for (int i = 0; i < 4; i++) if (!(ph == P_GREEN && i == dir) && car[i]) mp[i] = 1'b1;
    if (nph == P_GREEN && ph != P_GREEN) mp[ndir] = 1'b0;
    mped = mped | ped;
    if (nph == P_WALK && ph != P_WALK) mped = 1'b0;
    if (ped_again) mped = 1'b1;
    age = (nph != ph) ? 0 : age + 1;
    ph = nph; dir = ndir; mem = nem;
  endtask

  function automatic obs_t model_out();
    obs_t o;
    logic [1:0] l[4];
    for (int i = 0; i < 4; i++)
      l[i] = (i == dir && ph == P_GREEN) ? 2'b10 : (i == dir && ph == P_YELLOW) ? 2'b01 : 2'b00;
    o.n = l[0]; o.e = l[1]; o.s = l[2]; o.w = l[3];
    o.walk = (ph == P_WALK);
    o.dir = 2'(dir);
    o.pend = mp;
    o.em = mem;
    return o;
  endfunction

  // Drive one cycle of stimulus at the falling edge and queue what the DUT must show next.
  task automatic cyc(input logic [3:0] c, input logic p, input logic ev, input logic [1:0] ed, input logic r);
    @(negedge clk);
    cycle++;
    car_req = c; ped_req = p; emerg_valid = ev; emerg_dir = ed;
    if (r && !reset) begin
      model_reset();
      sb.push_back(model_out());
    end
    reset = r;
    if (r) model_reset();
    else model_step(c, p, ev, ed);
    sb.push_back(model_out());
  endtask

  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk or posedge reset);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = '{light_n, light_e, light_s, light_w, ped_walk, phase_dir, pending, emerg_active};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs cycle %0d: got n=%b e=%b s=%b w=%b walk=%b dir=%0d pend=%b em=%b, expected n=%b e=%b s=%b w=%b walk=%b dir=%0d pend=%b em=%b",
                   cycle, a.n, a.e, a.s, a.w, a.walk, a.dir, a.pend, a.em, e.n, e.e, e.s, e.w, e.walk, e.dir, e.pend, e.em);
        end
      end
    end
  end

  initial begin
    int em_left;
    logic [1:0] ed;
    logic [3:0] c;
    reset = 1'b1; car_req = '0; ped_req = 1'b0; emerg_valid = 1'b0; emerg_dir = '0;
    model_reset();
    repeat (2) cyc(4'b0000, 1'b0, 1'b0, 2'd0, 1'b1);
    repeat (3) cyc(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    cyc(4'b0001, 1'b0, 1'b0, 2'd0, 1'b0);
    repeat (8) cyc(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    cyc(4'b0011, 1'b0, 1'b0, 2'd0, 1'b0);
    repeat (14) cyc(4'b0001, 1'b0, 1'b0, 2'd0, 1'b0);
    repeat (4) cyc(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    cyc(4'b1101, 1'b0, 1'b0, 2'd0, 1'b0);
    repeat (40) cyc(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    cyc(4'b0010, 1'b1, 1'b0, 2'd0, 1'b0);
    repeat (25) cyc(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    repeat (24) cyc(4'b0000, 1'b0, 1'b1, 2'd2, 1'b0);
    cyc(4'b0110, 1'b0, 1'b1, 2'd2, 1'b0);
    cyc(4'b0000, 1'b0, 1'b1, 2'd2, 1'b1);
    cyc(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    em_left = 0; ed = 2'd0;
    for (int t = 0; t < 4000; t++) begin
      if (em_left == 0 && $urandom_range(0, 60) == 0) begin
        em_left = $urandom_range(3, 25);
        ed = 2'($urandom_range(0, 3));
      end else if (em_left > 0) begin
        em_left--;
        if ($urandom_range(0, 39) == 0) ed = 2'($urandom_range(0, 3));
      end
      for (int i = 0; i < 4; i++) c[i] = ($urandom_range(0, 9) == 0);
      cyc(c, $urandom_range(0, 29) == 0, em_left > 0, ed, $urandom_range(0, 499) == 0);
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
